// File: rtl/clk_div_sel_if.sv
// Selection request bus for clk_div_sel: valid/ready request plus done/err
// completion pulses and the currently active tap index.
interface clk_div_sel_if;
    logic [1:0] sel;
    logic       sel_valid;
    logic       sel_ready;
    logic [1:0] sel_active;
    logic       done;
    logic       err;

    modport master (
        output sel,
        output sel_valid,
        input  sel_ready,
        input  sel_active,
        input  done,
        input  err
    );

    modport slave (
        input  sel,
        input  sel_valid,
        output sel_ready,
        output sel_active,
        output done,
        output err
    );
endinterface

// File: rtl/clk_div_sel.sv
// Glitch-free divided-clock tap selector: re-registers one divider tap and switches taps only at the all-zero boundary.
// Optional output gating via `define CLK_DIV_SEL_GATE_EN (adds input out_en).
module clk_div_sel #(
    parameter int RST_SEL = 0,
    parameter int TIMEOUT = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [3:0]   div_in,
`ifdef CLK_DIV_SEL_GATE_EN
    input  logic         out_en,
`endif
    clk_div_sel_if.slave bus,
    output logic         clk_out,
    output logic         rise_pulse
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [1:0] SEL_RST = 2'(RST_SEL);

    typedef enum logic {
        S_IDLE,
        S_PEND
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_pend_sel;
    logic [1:0]       r_sel_active;
    logic             r_sel_ready;
    logic             r_done;
    logic             r_err;
    logic             r_clk_out;
    logic             r_rise;

    logic w_tap;
    logic w_boundary;
    logic w_out_nxt;

    assign w_tap      = div_in[r_sel_active];
    assign w_boundary = (div_in == 4'b0000);

`ifdef CLK_DIV_SEL_GATE_EN
    logic r_gated;
    logic w_gated_nxt;

    // Gate state may only change while the selected tap is low, so a high phase is never cut short.
    // NOTE: always_comb assigns a default first so no latch is inferred.
    always_comb begin
        w_gated_nxt = r_gated;
        if (!w_tap) begin
            w_gated_nxt = !out_en;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_gated <= 1'b0;
        end else begin
            r_gated <= w_gated_nxt;
        end
    end

    assign w_out_nxt = w_tap & ~w_gated_nxt;
`else
    assign w_out_nxt = w_tap;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_clk_out <= 1'b0;
            r_rise    <= 1'b0;
        end else begin
            r_clk_out <= w_out_nxt;
            r_rise    <= w_out_nxt & ~r_clk_out;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_pend_sel   <= 2'b00;
            r_sel_active <= SEL_RST;
            r_sel_ready  <= 1'b1;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.sel_valid) begin
                        r_pend_sel <= bus.sel;
                        if (bus.sel == r_sel_active) begin
                            r_done <= 1'b1;
                        end else begin
                            r_state     <= S_PEND;
                            r_sel_ready <= 1'b0;
                            r_cnt       <= '0;
                        end
                    end
                end
                S_PEND: begin
                    // Boundary takes priority over an expiring timeout in the same cycle.
                    if (w_boundary) begin
                        r_sel_active <= r_pend_sel;
                        r_done       <= 1'b1;
                        r_state      <= S_IDLE;
                        r_sel_ready  <= 1'b1;
                    end else if (r_cnt == CNT_LAST) begin
                        r_err       <= 1'b1;
                        r_state     <= S_IDLE;
                        r_sel_ready <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_sel_ready <= 1'b1;
                end
            endcase
        end
    end

    assign bus.sel_ready  = r_sel_ready;
    assign bus.sel_active = r_sel_active;
    assign bus.done       = r_done;
    assign bus.err        = r_err;
    assign clk_out        = r_clk_out;
    assign rise_pulse     = r_rise;

endmodule

// File: tb/tb_clk_div_sel.sv
// Directed bench for clk_div_sel: vector table for the running-divider path plus
// hand sequences for timeout, boundary-at-accept, boundary/timeout tie and reset mid-request.
module tb_clk_div_sel;

    logic       clk;
    logic       rst;
    logic [3:0] div_in;
    logic       clk_out;
    logic       rise_pulse;
    int         checks;
    int         errors;

    clk_div_sel_if u_if ();

`ifdef CLK_DIV_SEL_GATE_EN
    logic out_en;
    initial out_en = 1'b1;
`endif

    clk_div_sel #(
        .RST_SEL (0),
        .TIMEOUT (64)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .div_in     (div_in),
`ifdef CLK_DIV_SEL_GATE_EN
        .out_en     (out_en),
`endif
        .bus        (u_if.slave),
        .clk_out    (clk_out),
        .rise_pulse (rise_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] d;
        logic [1:0] s;
        logic       v;
        logic       c;
        logic       r;
        logic       rdy;
        logic [1:0] a;
        logic       dn;
        logic       er;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [3:0] d, input logic [1:0] s, input logic v,
                       input logic c, input logic r, input logic rdy,
                       input logic [1:0] a, input logic dn, input logic er);
        vec_t e;
        e.d = d; e.s = s; e.v = v; e.c = c; e.r = r;
        e.rdy = rdy; e.a = a; e.dn = dn; e.er = er;
        tbl.push_back(e);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] d, input logic [1:0] s, input logic v);
        div_in       = d;
        u_if.sel       = s;
        u_if.sel_valid = v;
    endtask

    initial begin
        logic [3:0] d;
        checks = 0;
        errors = 0;
        rst    = 1'b0;
        drive(4'd0, 2'd0, 1'b0);

        // d, sel, valid, clk_out, rise, ready, active, done, err
        add(4'd1, 2'd0, 1'b0, 1'b1, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0);
        add(4'd2, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0);
        add(4'd3, 2'd0, 1'b1, 1'b1, 1'b1, 1'b1, 2'd0, 1'b1, 1'b0);
        add(4'd4, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0);
        add(4'd5, 2'd3, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
        add(4'd6, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
        add(4'd7, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
        for (int k = 8; k <= 15; k++) begin
            add(4'(k), 2'd0, 1'b0, k[0], k[0], 1'b0, 2'd0, 1'b0, 1'b0);
        end
        add(4'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 1'b1, 1'b0);
        add(4'd1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 1'b0, 1'b0);

        tick();
        tick();
        check("rst_clk_out", {31'd0, clk_out}, 32'd0);
        check("rst_rise", {31'd0, rise_pulse}, 32'd0);
        check("rst_done_err", {30'd0, u_if.done, u_if.err}, 32'd0);
        check("rst_ready", {31'd0, u_if.sel_ready}, 32'd1);
        check("rst_active", {30'd0, u_if.sel_active}, 32'd0);
        rst = 1'b1;

        foreach (tbl[i]) begin
            drive(tbl[i].d, tbl[i].s, tbl[i].v);
            tick();
            check($sformatf("vec%0d_clk_out", i), {31'd0, clk_out}, {31'd0, tbl[i].c});
            check($sformatf("vec%0d_rise", i), {31'd0, rise_pulse}, {31'd0, tbl[i].r});
            check($sformatf("vec%0d_ready", i), {31'd0, u_if.sel_ready}, {31'd0, tbl[i].rdy});
            check($sformatf("vec%0d_active", i), {30'd0, u_if.sel_active}, {30'd0, tbl[i].a});
            check($sformatf("vec%0d_done", i), {31'd0, u_if.done}, {31'd0, tbl[i].dn});
            check($sformatf("vec%0d_err", i), {31'd0, u_if.err}, {31'd0, tbl[i].er});
        end

        // Divide-by-16 after the switch: clk_out follows div_in[3], rising only at count 8.
        d = 4'd1;
        for (int k = 0; k < 40; k++) begin
            d = d + 4'd1;
            drive(d, 2'd0, 1'b0);
            tick();
            check($sformatf("div16_clk_d%0d", d), {31'd0, clk_out}, {31'd0, d[3]});
            check($sformatf("div16_rise_d%0d", d), {31'd0, rise_pulse}, {31'd0, (d == 4'd8)});
        end

        // Frozen divider at 0101: the request must time out after 64 cycles.
        rst = 1'b0;
        #2;
        rst = 1'b1;
        drive(4'b0101, 2'd2, 1'b1);
        tick();
        check("to_accept_ready", {31'd0, u_if.sel_ready}, 32'd0);
        drive(4'b0101, 2'd0, 1'b0);
        for (int k = 1; k <= 63; k++) begin
            tick();
            check($sformatf("to_wait%0d", k), {29'd0, u_if.done, u_if.err, u_if.sel_ready}, 32'd0);
        end
        tick();
        check("to_err", {31'd0, u_if.err}, 32'd1);
        check("to_done", {31'd0, u_if.done}, 32'd0);
        check("to_active", {30'd0, u_if.sel_active}, 32'd0);
        check("to_ready", {31'd0, u_if.sel_ready}, 32'd1);
        check("to_clk_out", {31'd0, clk_out}, 32'd1);
        tick();
        check("to_err_one_cycle", {31'd0, u_if.err}, 32'd0);

        // Accept during a boundary cycle: no switch until the next boundary.
        drive(4'd0, 2'd1, 1'b1);
        tick();
        check("bacc_ready", {31'd0, u_if.sel_ready}, 32'd0);
        check("bacc_active", {30'd0, u_if.sel_active}, 32'd0);
        check("bacc_done", {31'd0, u_if.done}, 32'd0);
        for (int k = 1; k <= 15; k++) begin
            drive(4'(k), 2'd0, 1'b0);
            tick();
            check($sformatf("bacc_wait%0d", k),
                  {28'd0, u_if.done, u_if.err, u_if.sel_active}, 32'd0);
        end
        drive(4'd0, 2'd0, 1'b0);
        tick();
        check("bacc_switch_active", {30'd0, u_if.sel_active}, 32'd1);
        check("bacc_switch_done", {31'd0, u_if.done}, 32'd1);
        check("bacc_switch_ready", {31'd0, u_if.sel_ready}, 32'd1);

        // Boundary on the last timeout cycle: switch wins, no err.
        drive(4'd5, 2'd2, 1'b1);
        tick();
        drive(4'd5, 2'd0, 1'b0);
        for (int k = 1; k <= 63; k++) begin
            tick();
        end
        check("tie_pending_active", {30'd0, u_if.sel_active}, 32'd1);
        drive(4'd0, 2'd0, 1'b0);
        tick();
        check("tie_done", {31'd0, u_if.done}, 32'd1);
        check("tie_err", {31'd0, u_if.err}, 32'd0);
        check("tie_active", {30'd0, u_if.sel_active}, 32'd2);
        drive(4'd1, 2'd0, 1'b0);
        tick();
        check("tie_after", {30'd0, u_if.done, u_if.err}, 32'd0);

        // Reset during PEND drops the request without done/err.
        drive(4'd3, 2'd3, 1'b1);
        tick();
        check("rpend_ready", {31'd0, u_if.sel_ready}, 32'd0);
        drive(4'd4, 2'd0, 1'b0);
        tick();
        #3;
        rst = 1'b0;
        #1;
        check("rpend_active", {30'd0, u_if.sel_active}, 32'd0);
        check("rpend_ready_rst", {31'd0, u_if.sel_ready}, 32'd1);
        check("rpend_outs", {28'd0, clk_out, rise_pulse, u_if.done, u_if.err}, 32'd0);
        #1;
        rst = 1'b1;
        d = 4'd4;
        for (int k = 0; k < 18; k++) begin
            d = d + 4'd1;
            drive(d, 2'd0, 1'b0);
            tick();
            check($sformatf("rpend_after%0d", k),
                  {28'd0, u_if.done, u_if.err, u_if.sel_active}, 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
